div_monitor: RTL



---
 rtl/div_mon_pkg.sv | 14 +
 rtl/sync_edge_det.sv | 38 +++
 rtl/div_monitor.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/div_mon_pkg.sv
// Shared types and default parameters for the divided-clock monitor.
package div_mon_pkg;

    localparam int unsigned DEF_CNT_W       = 8;
    localparam int unsigned DEF_LOCK_CNT    = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2
    } mon_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous input through a flop chain and
// produces a single-cycle pulse on its synchronized rising edge.
module sync_edge_det
    import div_mon_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic sync_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain_q, chain_d;
    logic                   prev_q,  prev_d;

    // Next-state of the synchronizer chain and the delayed copy for edge detect
    always_comb begin
        chain_d = {chain_q[SYNC_STAGES-2:0], sig_in};
        prev_d  = chain_q[SYNC_STAGES-1];
    end

    // Register the chain; reset clears every stage
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
            prev_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign sync_in = chain_q[SYNC_STAGES-1];
    assign rise    = sync_in & ~prev_q;

endmodule

// File: rtl/div_monitor.sv
// Divided-clock monitor: measures rising-to-rising period and high time
// of sig_in in clk cycles, tracks period stability (lock) and flags a
// sticky timeout when no edge arrives within the counter range.
module div_monitor
    import div_mon_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned LOCK_CNT    = DEF_LOCK_CNT,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int unsigned      MATCH_W    = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(LOCK_CNT);
    localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);

    logic sync_in;
    logic rise;

    mon_state_e         state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [CNT_W-1:0]   hcnt_q,    hcnt_d;
    logic [CNT_W-1:0]   period_q,  period_d;
    logic [CNT_W-1:0]   high_q,    high_d;
    logic [CNT_W-1:0]   ref_q,     ref_d;
    logic [MATCH_W-1:0] match_q,   match_d;
    logic               mv_q,      mv_d;
    logic               locked_q,  locked_d;
    logic               timeout_q, timeout_d;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .sig_in  (sig_in),
        .sync_in (sync_in),
        .rise    (rise)
    );

    // Next-state logic: FSM, interval counters, lock tracking and timeout
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hcnt_d    = hcnt_q;
        period_d  = period_q;
        high_d    = high_q;
        ref_d     = ref_q;
        match_d   = match_q;
        mv_d      = 1'b0;
        timeout_d = timeout_q;

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            hcnt_d  = '0;
            match_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = WAIT_RISE;
                    cnt_d   = '0;
                    hcnt_d  = '0;
                end
                // cnt also runs while waiting so a dead input is flagged
                // even before the first edge is ever seen
                WAIT_RISE: begin
                    if (rise) begin
                        state_d = MEASURE;
                        cnt_d   = CNT_ONE;
                        hcnt_d  = CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        match_d   = '0;
                        cnt_d     = '0;
                        hcnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d  = cnt_q;
                        high_d    = hcnt_q;
                        mv_d      = 1'b1;
                        timeout_d = 1'b0;
                        cnt_d     = CNT_ONE;
                        hcnt_d    = CNT_ONE;
                        if (cnt_q == ref_q) begin
                            if (match_q != MATCH_FULL) begin
                                match_d = match_q + MATCH_ONE;
                            end
                        end else begin
                            ref_d   = cnt_q;
                            match_d = MATCH_ONE;
                        end
                    end else if (cnt_q == CNT_MAX) begin
                        state_d   = WAIT_RISE;
                        timeout_d = 1'b1;
                        match_d   = '0;
                        cnt_d     = '0;
                        hcnt_d    = '0;
                    end else begin
                        cnt_d  = cnt_q + CNT_ONE;
                        hcnt_d = hcnt_q + CNT_W'(sync_in);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        locked_d = (match_d == MATCH_FULL);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            period_q  <= '0;
            high_q    <= '0;
            ref_q     <= '0;
            match_q   <= '0;
            mv_q      <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            ref_q     <= ref_d;
            match_q   <= match_d;
            mv_q      <= mv_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = mv_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule
